// File: rtl/adder_pkg.sv
// Shared operation type and bit-level helpers for the pipelined add/subtract unit.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Carry into a full-adder bit, recovered from its two operand bits and its sum bit.
    function automatic logic carry_into(input logic a_bit, input logic b_bit, input logic s_bit);
        return a_bit ^ b_bit ^ s_bit;
    endfunction

    function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

    function automatic logic eff_carry(input op_t op, input logic cin);
        return (op == OP_SUB) ? 1'b1 : cin;
    endfunction

    function automatic logic [63:0] eff_operand_b(input op_t op, input logic [63:0] b);
        return (op == OP_SUB) ? ~b : b;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One registered CW-bit slice of the carry-chained adder; the full-width operand words
// rotate right by CW each stage so the next chunk always sits in the low bits.
module adder_pipe_stage
    import adder_pkg::*;
#(
    parameter int CW = 8,
    parameter int W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         valid_i,
    input  logic         carry_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         valid_o,
    output logic         carry_o,
    output logic         ovf_o,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    logic [CW:0]  chunk_d;
    logic [W-1:0] a_d;
    logic [W-1:0] b_d;
    logic         ovf_d;

    logic         valid_q;
    logic         carry_q;
    logic         ovf_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;

    assign chunk_d = {1'b0, a_i[CW-1:0]} + {1'b0, b_i[CW-1:0]} + {{CW{1'b0}}, carry_i};

    // Only meaningful in the last stage, where the chunk MSB is the word MSB.
    assign ovf_d = signed_ovf(carry_into(a_i[CW-1], b_i[CW-1], chunk_d[CW-1]), chunk_d[CW]);

    generate
        if (CW == W) begin : g_full
            assign a_d = chunk_d[CW-1:0];
            assign b_d = '0;
        end else begin : g_rot
            // The finished sum chunk enters at the top; after all stages the word is in place.
            assign a_d = {chunk_d[CW-1:0], a_i[W-1:CW]};
            assign b_d = {{CW{1'b0}}, b_i[W-1:CW]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (en) begin
            valid_q <= valid_i;
            carry_q <= chunk_d[CW];
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign valid_o = valid_q;
    assign carry_o = carry_q;
    assign ovf_o   = ovf_q;
    assign a_o     = a_q;
    assign b_o     = b_q;

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined BIT_WIDTH-bit add/subtract split into STAGES carry-chained chunks with a
// global-stall valid/ready handshake. Define ADDER_XCHECK_EN for X/Z operand assertions.
module adder_pipe_nbit
    import adder_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int STAGES    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    input  op_t                  op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 carry_out,
    output logic                 overflow
);

    localparam int CW = BIT_WIDTH / STAGES;

    logic                 adv;
    logic                 vld_bus [0:STAGES];
    logic                 cy_bus  [0:STAGES];
    logic [BIT_WIDTH-1:0] a_bus   [0:STAGES];
    logic [BIT_WIDTH-1:0] b_bus   [0:STAGES];
    logic [STAGES-1:0]    ovf_vec;
    logic [63:0]          b_wide;
    logic                 unused_sink;

    // One shared enable: the whole pipe either shifts together or holds.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign b_wide     = eff_operand_b(op, {{(64-BIT_WIDTH){1'b0}}, b});
    assign vld_bus[0] = in_valid;
    assign cy_bus[0]  = eff_carry(op, carry_in);
    assign a_bus[0]   = a;
    assign b_bus[0]   = b_wide[BIT_WIDTH-1:0];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            adder_pipe_stage #(
                .CW (CW),
                .W  (BIT_WIDTH)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en      (adv),
                .valid_i (vld_bus[k]),
                .carry_i (cy_bus[k]),
                .a_i     (a_bus[k]),
                .b_i     (b_bus[k]),
                .valid_o (vld_bus[k+1]),
                .carry_o (cy_bus[k+1]),
                .ovf_o   (ovf_vec[k]),
                .a_o     (a_bus[k+1]),
                .b_o     (b_bus[k+1])
            );
        end
    endgenerate

    assign out_valid = vld_bus[STAGES];
    assign sum       = a_bus[STAGES];
    assign carry_out = cy_bus[STAGES];
    assign overflow  = ovf_vec[STAGES-1];

    // Intermediate overflow flags and the exhausted B word have no consumer.
    assign unused_sink = ^{ovf_vec, b_bus[STAGES], b_wide};

`ifdef ADDER_XCHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!$isunknown(in_valid) && !$isunknown(out_ready))
                else $error("handshake input unknown after reset");
            if (in_valid && in_ready) begin
                assert (!$isunknown({a, b, op}) && (op == OP_SUB || !$isunknown(carry_in)))
                    else $error("non-digital operand");
            end
        end
    end
`else
    // Operand X/Z checking compiled out.
`endif

endmodule
